// File: rtl/filter_window_7x7_gen.sv
// filter_window_7x7_gen: turns a raster pixel stream into a sliding 7x7
// neighbourhood for the 7x7 median stage. Six chained line buffers supply
// the six older rows. A 7x7 register window shifts left on every accepted
// pixel. A position tracker decides when a full window is available.

// One line of pixel storage with a registered read port.
// A read and a write to the same address in one cycle return the old word.
module filter_window_7x7_linebuf #(
    parameter int PW    = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [PW-1:0] rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [PW-1:0] wr_data_i
);
    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_q;

    // Storage array: not reset, because every location is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (rd_en_i) rd_q <= mem_q[rd_addr_i];
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = rd_q;
endmodule

module filter_window_7x7_gen #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int LINE_SIZE_MAX = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PIXEL_WIDTH-1:0]    di,
    input  logic                      di_valid,
    input  logic                      di_sof,
    input  logic                      di_eol,
    output logic [49*PIXEL_WIDTH-1:0] xo,
    output logic                      xo_valid,
    output logic                      xo_sof,
    output logic                      xo_eol,
    output logic                      err_line_ovf
);
    localparam int PW   = PIXEL_WIDTH;
    localparam int AW   = $clog2(LINE_SIZE_MAX);
    localparam int NBUF = 6;
    localparam logic [AW-1:0] COL_LAST = AW'(LINE_SIZE_MAX - 1);
    localparam logic [AW-1:0] COL_WIN  = AW'(6);

    typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] col_cnt_q, col_cnt_d;
    logic [2:0]    row_cnt_q, row_cnt_d;
    logic          full_q, full_d;       // slot LINE_SIZE_MAX-1 of this line already used
    logic          sof_pend_q, sof_pend_d;
    logic          err_q, err_d;

    // Position of the pixel on the input this cycle (di_sof overrides the counters).
    logic [AW-1:0] col_cur;
    logic [2:0]    row_cur;
    logic          full_cur, pend_cur;
    logic          accept, wr, drop, win_ok;

    // Stage 1: line-buffer read data plus the matching delayed pixel and flags.
    logic [NBUF-1:0][PW-1:0] lb_rd;
    logic          s1_shift_q;
    logic [AW-1:0] s1_addr_q;
    logic [PW-1:0] s1_di_q;
    logic          s1_sof_q, s1_eol_q;
    logic [1:0]    win_vld_q;            // [0] stage 1, [1] drives xo_valid

    // Stage 2: live window and the held output copy.
    logic [6:0][6:0][PW-1:0] win_q, win_d, xo_q;
    logic          xo_sof_q, xo_eol_q;

    // Next state, counter updates and accept/drop decisions.
    always_comb begin
        state_d    = state_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        full_d     = full_q;
        sof_pend_d = sof_pend_q;
        err_d      = err_q;
        col_cur    = col_cnt_q;
        row_cur    = row_cnt_q;
        full_cur   = full_q;
        pend_cur   = sof_pend_q;
        if (di_sof) begin
            col_cur  = '0;
            row_cur  = '0;
            full_cur = 1'b0;
            pend_cur = 1'b1;
        end
        accept = di_valid && (state_q == ACTIVE || di_sof);
        wr     = accept && !full_cur;
        drop   = accept && full_cur;
        win_ok = wr && (row_cur == 3'd6) && (col_cur >= COL_WIN);
        if (accept) begin
            state_d    = ACTIVE;
            sof_pend_d = pend_cur && !win_ok;
            if (di_sof) err_d = 1'b0;
            if (drop)   err_d = 1'b1;
            if (di_eol) begin
                // A dropped eol pixel still ends the line, so the tracker recovers.
                col_cnt_d = '0;
                full_d    = 1'b0;
                row_cnt_d = (row_cur == 3'd6) ? 3'd6 : row_cur + 3'd1;
            end else begin
                row_cnt_d = row_cur;
                col_cnt_d = col_cur;
                full_d    = full_cur;
                if (!full_cur) begin
                    if (col_cur == COL_LAST) full_d = 1'b1;
                    else                     col_cnt_d = col_cur + 1'b1;
                end
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_SOF;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            full_q     <= 1'b0;
            sof_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            full_q     <= full_d;
            sof_pend_q <= sof_pend_d;
            err_q      <= err_d;
        end
    end

    // Line-buffer chain. Buffer 0 takes di directly. Buffer n takes buffer n-1's
    // read data one cycle later at the same address. Back-to-back pixels only
    // share an address on 1-pixel lines, and those lines never form a window.
    for (genvar n = 0; n < NBUF; n++) begin : g_lb
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [PW-1:0] wr_data;
        if (n == 0) begin : g_head
            assign wr_en   = wr;
            assign wr_addr = col_cur;
            assign wr_data = di;
        end else begin : g_tail
            assign wr_en   = s1_shift_q;
            assign wr_addr = s1_addr_q;
            assign wr_data = lb_rd[n-1];
        end
        filter_window_7x7_linebuf #(.PW(PW), .DEPTH(LINE_SIZE_MAX), .AW(AW)) u_lb (
            .clk       (clk),
            .rd_en_i   (wr),
            .rd_addr_i (col_cur),
            .rd_data_o (lb_rd[n]),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data)
        );
    end

    // Stage 1 registers: delayed pixel, write-back address and window flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_shift_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_di_q    <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            win_vld_q  <= '0;
        end else begin
            s1_shift_q <= wr;
            s1_addr_q  <= col_cur;
            s1_di_q    <= di;
            s1_sof_q   <= win_ok && pend_cur;
            s1_eol_q   <= win_ok && di_eol;
            win_vld_q  <= {win_vld_q[0], win_ok};
        end
    end

    // Window shifted one column left, with the new right column (oldest line at row 0).
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 6; c++)
                win_d[r][c] = win_q[r][c+1];
        win_d[6][6] = s1_di_q;
        for (int n = 0; n < NBUF; n++)
            win_d[5-n][6] = lb_rd[n];
    end

    // Stage 2: shift the window, and capture the output copy only for complete windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= '0;
            xo_q     <= '0;
            xo_sof_q <= 1'b0;
            xo_eol_q <= 1'b0;
        end else begin
            if (s1_shift_q)   win_q <= win_d;
            if (win_vld_q[0]) xo_q  <= win_d;
            xo_sof_q <= s1_sof_q;
            xo_eol_q <= s1_eol_q;
        end
    end

    assign xo           = xo_q;
    assign xo_valid     = win_vld_q[1];
    assign xo_sof       = xo_sof_q;
    assign xo_eol       = xo_eol_q;
    assign err_line_ovf = err_q;
endmodule

// File: tb/tb_filter_window_7x7_gen.sv
// Bench for filter_window_7x7_gen. The driver feeds pixels and pushes the
// windows that a frame-image model predicts. The monitor pops a window at each
// xo_valid and checks its content, its flags and its arrival cycle.
module tb_filter_window_7x7_gen;
    localparam int PW   = 8;
    localparam int LMAX = 1024;
    localparam int XW   = 49 * PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] di = '0;
    logic          di_valid = 1'b0, di_sof = 1'b0, di_eol = 1'b0;
    logic [XW-1:0] xo;
    logic          xo_valid, xo_sof, xo_eol, err_line_ovf;

    filter_window_7x7_gen #(.PIXEL_WIDTH(PW), .LINE_SIZE_MAX(LMAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .di           (di),
        .di_valid     (di_valid),
        .di_sof       (di_sof),
        .di_eol       (di_eol),
        .xo           (xo),
        .xo_valid     (xo_valid),
        .xo_sof       (xo_sof),
        .xo_eol       (xo_eol),
        .err_line_ovf (err_line_ovf)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nerr = 0, n_pop = 0;

    typedef struct {
        logic [XW-1:0] xo;
        bit            sof;
        bit            eol;
        longint        cyc;
    } exp_t;
    exp_t          q[$];
    logic [XW-1:0] last_exp = '0;

    // Model: the frame as seen so far, indexed by line and column.
    bit            m_act = 0, m_pend = 0, m_err = 0;
    int            m_r = 0, m_c = 0;
    logic [PW-1:0] img [16][LMAX];

    task automatic chk(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_step(input logic [PW-1:0] v, input bit sof, input bit eol);
        exp_t e;
        if (!m_act && !sof) return;
        if (sof) begin
            m_act = 1; m_r = 0; m_c = 0; m_pend = 1; m_err = 0;
        end
        if (m_c >= LMAX) m_err = 1;
        else begin
            img[m_r % 16][m_c] = v;
            if (m_r >= 6 && m_c >= 6) begin
                e.xo = '0;
                for (int i = 0; i < 7; i++)
                    for (int j = 0; j < 7; j++)
                        e.xo[(i*7+j)*PW +: PW] = img[(m_r-6+i) % 16][m_c-6+j];
                e.sof = m_pend;
                e.eol = eol;
                e.cyc = cyc + 2;
                q.push_back(e);
                m_pend = 0;
            end
        end
        if (eol) begin m_r++; m_c = 0; end
        else m_c++;
    endfunction

    // One clock of input; also checks the error flag the previous cycle produced.
    task automatic px(input logic [PW-1:0] v, input bit sof, input bit eol, input bit valid);
        @(posedge clk); #1;
        chk_i("err_line_ovf", int'(err_line_ovf), int'(m_err));
        di = v; di_sof = sof; di_eol = eol; di_valid = valid;
        if (valid) model_step(v, sof, eol);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            px(PW'($urandom), bit'($urandom_range(1)), bit'($urandom_range(1)), 1'b0);
    endtask

    // mode 0: ramp r*10+c, 1: constant base, 2: random.
    task automatic send_frame(input int w, input int h, input int mode, input int base, input int gap);
        logic [PW-1:0] v;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                while (gap > 0 && $urandom_range(99) < gap) idle(1);
                v = (mode == 0) ? PW'(r*10 + c) : (mode == 1) ? PW'(base) : PW'($urandom);
                px(v, (r == 0 && c == 0), (c == w - 1), 1'b1);
            end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_xo"}, xo, '0);
        chk_i({tag, "_xo_valid"}, int'(xo_valid), 0);
        chk_i({tag, "_xo_sof"}, int'(xo_sof), 0);
        chk_i({tag, "_xo_eol"}, int'(xo_eol), 0);
        chk_i({tag, "_err"}, int'(err_line_ovf), 0);
    endtask

    // Monitor: every window must arrive exactly on its predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    nvec++; nerr++;
                    $display("FAIL missing_window: got none expected one at cycle %0d", q[0].cyc);
                    void'(q.pop_front());
                end
                if (xo_valid) begin
                    if (q.size() == 0 || q[0].cyc != cyc) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_valid: got 1 expected 0 at cycle %0d", cyc);
                    end else begin
                        e = q.pop_front();
                        chk("xo", xo, e.xo);
                        chk_i("xo_sof", int'(xo_sof), int'(e.sof));
                        chk_i("xo_eol", int'(xo_eol), int'(e.eol));
                        last_exp = e.xo;
                        n_pop++;
                    end
                end else begin
                    chk("xo_hold", xo, last_exp);
                    chk_i("flags_idle", int'({xo_sof, xo_eol}), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, w, h;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Ramp frame, continuous.
        n0 = n_pop;
        send_frame(10, 10, 0, 0, 0);
        idle(5);
        chk_i("ramp_count", n_pop - n0, 16);

        // Ramp frame with 50% idle cycles.
        n0 = n_pop;
        send_frame(10, 10, 0, 0, 50);
        idle(5);
        chk_i("gap_count", n_pop - n0, 16);

        // Reset mid-frame in line 8.
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 10; c++)
                if (!(r == 8 && c > 3)) px(PW'(r*10 + c), (r == 0 && c == 0), (c == 9), 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0; di_valid = 1'b0;
        #1 check_reset_outputs("async_reset");
        q.delete(); last_exp = '0; m_act = 0; m_err = 0; m_pend = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) px(PW'($urandom), 1'b0, (i == 2), 1'b1);
        n0 = n_pop;
        send_frame(10, 10, 0, 0, 0);
        idle(5);
        chk_i("post_reset_count", n_pop - n0, 16);

        // Pixels before sof, then undersized frames (an active frame is already
        // finished, so reset first to exercise the ignored-before-sof path).
        @(posedge clk);
        #3 rst_n = 1'b0;
        q.delete(); last_exp = '0; m_act = 0; m_err = 0; m_pend = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n0 = n_pop;
        for (int i = 0; i < 20; i++) px(PW'($urandom), 1'b0, ($urandom_range(3) == 0), 1'b1);
        send_frame(5, 10, 2, 0, 0);
        send_frame(10, 6, 2, 0, 0);
        idle(5);
        chk_i("undersized_count", n_pop - n0, 0);

        // Line overflow: LMAX+2 pixels on one line, then a fresh frame.
        for (int c = 0; c < LMAX + 2; c++) px(PW'($urandom), (c == 0), (c == LMAX + 1), 1'b1);
        idle(3);
        chk_i("ovf_sticky", int'(err_line_ovf), 1);
        n0 = n_pop;
        send_frame(10, 10, 2, 0, 0);
        idle(5);
        chk_i("ovf_recover_count", n_pop - n0, 16);

        // Back-to-back frames of constants.
        n0 = n_pop;
        send_frame(10, 10, 1, 8'h11, 0);
        send_frame(10, 10, 1, 8'h22, 0);
        idle(5);
        chk_i("b2b_count", n_pop - n0, 32);

        // Frame restarted part-way through a line.
        send_frame(10, 8, 2, 0, 0);
        for (int c = 0; c < 4; c++) px(PW'($urandom), 1'b0, 1'b0, 1'b1);
        n0 = n_pop;
        send_frame(9, 9, 2, 0, 20);
        idle(5);
        chk_i("restart_count", n_pop - n0, 9);

        // Random sizes and gaps.
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(12, 7);
            h = $urandom_range(12, 7);
            n0 = n_pop;
            send_frame(w, h, 2, 0, 30);
            idle(4);
            chk_i("rand_count", n_pop - n0, (w - 6) * (h - 6));
        end

        idle(5);
        chk_i("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/filter_window_7x7_gen.md
# filter_window_7x7_gen

Upstream stage of the 7x7 median filter: converts a raster pixel stream into a sliding 7x7 neighbourhood, one full window per accepted pixel once seven lines and seven columns are available. The packed 49-pixel output feeds the 7x7 median entity directly, so window layout and width match its `xi` input. Internally it holds six line buffers, a 7x7 register window, and a frame/line position tracker.

## Interface
- `PIXEL_WIDTH`, 8, bits per pixel.
- `LINE_SIZE_MAX`, 1024, maximum pixels per line (line-buffer depth); power of two.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `di`  in  PIXEL_WIDTH  input pixel.
- `di_valid`  in  1  `di` is valid this cycle; may drop for any number of cycles.
- `di_sof`  in  1  qualified by `di_valid`; first pixel of a frame.
- `di_eol`  in  1  qualified by `di_valid`; last pixel of a line.
- `xo`  out  49*PIXEL_WIDTH  window; pixel k = row*7+col at `xo[k*PIXEL_WIDTH +: PIXEL_WIDTH]`. Row 0 is the oldest line (top); col 0 is the oldest pixel (left).
- `xo_valid`  out  1  `xo` holds a complete window.
- `xo_sof`  out  1  first window of the frame.
- `xo_eol`  out  1  window produced by an input pixel carrying `di_eol`.
- `err_line_ovf`  out  1  sticky; a line exceeded `LINE_SIZE_MAX` in the current frame.

## Operation
- States:
  - WAIT_SOF (reset state): every pixel is ignored until a valid pixel with `di_sof` arrives. That pixel moves the block to ACTIVE and counts as row 0, col 0.
  - ACTIVE: remains active until reset.
  - A `di_sof` seen in ACTIVE restarts the frame at row 0, col 0. The previous frame's partial state is discarded and no window mixes lines from two frames.
- Counters:
  - `col_cnt`: resets to 0 after a `di_eol` pixel and on `di_sof`. It saturates at `LINE_SIZE_MAX-1`.
  - `row_cnt`: increments on `di_eol`, saturates at 6, and resets on `di_sof`.
- Line buffers:
  - Six buffers are chained at address `col_cnt`, read-before-write.
  - Buffer 0 stores `di`, and buffer n stores buffer n-1's output.
- Window: on each accepted pixel, all 7 rows shift left one column. A new right column, col 6, is loaded: row 6 = `di`, row 5 = buffer 0, ..., row 0 = buffer 5.
- Window valid: a window is valid for an accepted pixel when `row_cnt`==6 and `col_cnt`>=6. Centre pixel = input at (row-3, col-3).
- Output frame size: an input frame of W x H yields (W-6) x (H-6) windows. Lines shorter than 7 pixels, or frames shorter than 7 lines, produce no `xo_valid`.
- Line overflow: pixels with `col_cnt` already at `LINE_SIZE_MAX-1` (beyond the limit) are not written, do not shift the window, and set `err_line_ovf`. `err_line_ovf` clears on the next `di_sof`.
- Line width consistency: lines are assumed equal width within a frame. With unequal widths the output is unspecified, but the block must not hang; recovery is on the next `di_sof`.
- `xo_sof`: asserted with the first valid window after each `di_sof` only.

## Timing
- Latency: fixed at 2 clk from `di_valid` of the completing pixel to `xo_valid`.
  - Cycle 1: line-buffer read and delayed `di`.
  - Cycle 2: registered window.
- Throughput: one window per clk at 100% `di_valid`.
- Gaps: idle cycles insert idle cycles; `xo_valid` is a single cycle per window.
- `xo` holds its value while `xo_valid`=0.
- `xo_sof` and `xo_eol` are single-cycle pulses and are only asserted with `xo_valid`=1.
- Reset: `rst_n`=0 asynchronously forces the following to 0: `xo`, `xo_valid`, `xo_sof`, `xo_eol`, `err_line_ovf`, counters and window registers. The state returns to WAIT_SOF. Line-buffer RAM contents are not reset and are never observed before rewrite.
- Simultaneous `di_sof` and `di_eol` on one pixel (1-pixel line): row 0 is completed and `row_cnt` becomes 1.

## Test plan
- **Ramp frame:** 10x10 frame, pixel = row*10+col, `di_valid` continuous.
  - Exactly 16 windows are produced.
  - First window: `xo[k]` = (k/7)*10 + k%7, with `xo_sof`=1.
  - `xo_eol` on windows 4, 8, 12, 16.
  - `xo_valid` first appears 2 clk after pixel (6,6).
- **Valid gaps:** same frame with `di_valid` random 50% → identical 16-window sequence; `xo_valid` never asserted on idle-induced cycles.
- **Pixels before sof, then undersized frame:**
  - 20 pixels before the first `di_sof` → ignored.
  - Then a 5x10 frame → `xo_valid` never asserted.
- **Line overflow:** line of `LINE_SIZE_MAX`+2 pixels → `err_line_ovf`=1 from the first dropped pixel; returns to 0 on the next `di_sof`.
- **Back-to-back frames:** frame A all 0x11, then frame B all 0x22 with `di_sof` in the next cycle → every window of B contains only 0x22.
- **Reset mid-frame:** `rst_n` low for 3 clk in line 8 of a ramp frame.
  - All outputs go to 0 without a clk edge.
  - Post-reset pixels before `di_sof` produce nothing.
  - A fresh 10x10 frame reproduces scenario 1 exactly.
